// File: rtl/multi_user_passcode_lock.sv
// Multi-user digit passcode lock: per-user PIN table, idle timeout, hold-timed grant/deny.
// Define MULTI_USER_PASSCODE_LOCKOUT_EN to add per-user failure counting and a LOCKED state.
module multi_user_passcode_lock #(
    parameter int DIGIT_W        = 4,
    parameter int PIN_LEN        = 4,
    parameter int NUM_USERS      = 4,
    parameter logic [NUM_USERS*PIN_LEN*DIGIT_W-1:0] PSWD_TABLE = 64'h0000_5555_9090_1234,
    parameter int HOLD_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 32,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    localparam int UID_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [UID_W-1:0]   userId,
    input  logic [DIGIT_W-1:0] userInp,
    input  logic               userBtn,
    output logic               accessGranted,
    output logic               accessDenied,
    output logic               locked,
    output logic [UID_W-1:0]   grantedUser,
    output logic [4:0]         digitCount
);

    localparam int MAXC0 = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int MAXC  = (MAXC0 > LOCKOUT_CYCLES) ? MAXC0 : LOCKOUT_CYCLES;
    localparam int TMR_W = $clog2(MAXC + 1);

    if (PIN_LEN < 1 || PIN_LEN > 16 || NUM_USERS < 1 || NUM_USERS > 16 || MAX_FAILS < 1)
        $error("multi_user_passcode_lock: parameter out of range");

    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, GRANT, DENY, LOCKED} state_t;

    state_t             state, nxt;
    logic               btnPrev, press, mmQ, digitBad, uidOk, lockHit;
    logic               grantQ, denyQ;
    logic [UID_W-1:0]   uidQ, selUser, gUserQ;
    logic [4:0]         selDigit;
    logic [DIGIT_W-1:0] expDigit;
    logic [TMR_W-1:0]   timer;

    assign press = userBtn & ~btnPrev & (state == IDLE || state == ENTRY);

    // In IDLE the first digit is checked against the live userId; afterwards the latched one.
    always_comb begin
        selUser  = (state == IDLE) ? userId : uidQ;
        selDigit = (state == IDLE) ? 5'd0 : digitCount;
        expDigit = '0;
        uidOk    = 1'b0;
        for (int u = 0; u < NUM_USERS; u++) begin
            if (selUser == UID_W'(u)) uidOk = 1'b1;
            for (int d = 0; d < PIN_LEN; d++)
                if (selUser == UID_W'(u) && selDigit == 5'(d))
                    expDigit = PSWD_TABLE[(u*PIN_LEN+d)*DIGIT_W +: DIGIT_W];
        end
        digitBad = !uidOk || (userInp != expDigit);
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:   if (press) nxt = (PIN_LEN == 1) ? CHECK : ENTRY;
            ENTRY: begin
                if (press) begin
                    if (digitCount == 5'(PIN_LEN-1)) nxt = CHECK;
                end else if (timer == TMR_W'(TIMEOUT_CYCLES-1)) begin
                    nxt = IDLE;
                end
            end
            CHECK:  nxt = mmQ ? DENY : GRANT;
            GRANT:  if (timer == TMR_W'(HOLD_CYCLES-1)) nxt = IDLE;
            DENY:   if (timer == TMR_W'(HOLD_CYCLES-1)) nxt = lockHit ? LOCKED : IDLE;
            LOCKED: if (timer == TMR_W'(LOCKOUT_CYCLES-1)) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btnPrev    <= 1'b0;
            timer      <= '0;
            digitCount <= '0;
            mmQ        <= 1'b0;
            uidQ       <= '0;
            grantQ     <= 1'b0;
            denyQ      <= 1'b0;
            gUserQ     <= '0;
        end else begin
            btnPrev <= userBtn;
            // One shared timer: idle time in ENTRY, hold time in GRANT/DENY/LOCKED.
            if (state != nxt || state == IDLE || press) timer <= '0;
            else                                        timer <= timer + 1'b1;
            if (press) begin
                digitCount <= (state == IDLE) ? 5'd1 : digitCount + 5'd1;
                mmQ        <= (state == IDLE) ? digitBad : (mmQ | digitBad);
                if (state == IDLE) uidQ <= userId;
            end else if (nxt == IDLE) begin
                digitCount <= '0;
            end
            grantQ <= (state == GRANT);
            denyQ  <= (state == DENY) || (state == LOCKED);
            gUserQ <= (state == GRANT) ? uidQ : '0;
        end
    end

    assign accessGranted = grantQ;
    assign accessDenied  = denyQ;
    assign grantedUser   = gUserQ;

`ifdef MULTI_USER_PASSCODE_LOCKOUT_EN
    localparam int FC_W = $clog2(MAX_FAILS + 1);

    logic [NUM_USERS-1:0][FC_W-1:0] failCnt;
    logic                           lockQ;

    always_comb begin
        lockHit = 1'b0;
        for (int u = 0; u < NUM_USERS; u++)
            if (uidQ == UID_W'(u) && failCnt[u] == FC_W'(MAX_FAILS)) lockHit = 1'b1;
    end

    // Out-of-range ids match no slot, so they never touch a counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            failCnt <= '0;
            lockQ   <= 1'b0;
        end else begin
            lockQ <= (state == LOCKED);
            for (int u = 0; u < NUM_USERS; u++) begin
                if (uidQ == UID_W'(u)) begin
                    if (state == CHECK && nxt == GRANT)
                        failCnt[u] <= '0;
                    else if (state == CHECK && nxt == DENY && failCnt[u] != FC_W'(MAX_FAILS))
                        failCnt[u] <= failCnt[u] + 1'b1;
                    else if (state == LOCKED && nxt == IDLE)
                        failCnt[u] <= '0;
                end
            end
        end
    end

    assign locked = lockQ;
`else
    assign lockHit = 1'b0;
    assign locked  = 1'b0;
`endif

endmodule

// File: tb/tb_multi_user_passcode_lock.sv
// Directed bench for multi_user_passcode_lock (default parameters).
// Expectations follow MULTI_USER_PASSCODE_LOCKOUT_EN when it is defined for the build.
module tb_multi_user_passcode_lock;

`ifdef MULTI_USER_PASSCODE_LOCKOUT_EN
    localparam int LK = 1;
`else
    localparam int LK = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] userId = '0;
    logic [3:0] userInp = '0;
    logic       userBtn = 1'b0;
    logic       accessGranted, accessDenied, locked;
    logic [1:0] grantedUser;
    logic [4:0] digitCount;

    int total = 0, bad = 0;
    int grantCyc = 0, denyCyc = 0, lockCyc = 0, bothCyc = 0;
    int g0, d0, l0;

    multi_user_passcode_lock dut (
        .clk(clk), .reset(reset), .userId(userId), .userInp(userInp), .userBtn(userBtn),
        .accessGranted(accessGranted), .accessDenied(accessDenied), .locked(locked),
        .grantedUser(grantedUser), .digitCount(digitCount)
    );

    always #5 clk = ~clk;

    // Cycle-level tallies of each output, sampled 1 time unit after every rising edge.
    always @(posedge clk) begin
        #1;
        if (accessGranted) grantCyc++;
        if (accessDenied) denyCyc++;
        if (locked) lockCyc++;
        if (accessGranted && accessDenied) bothCyc++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [1:0] uid, input logic [3:0] d);
        @(negedge clk);
        userId = uid; userInp = d; userBtn = 1'b1;
        @(negedge clk);
        userBtn = 1'b0;
    endtask

    task automatic enter4(input logic [1:0] uid, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] e);
        press(uid, a); press(uid, b); press(uid, c); press(uid, e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cycles(1);
        chk("rst_granted", accessGranted, 0);
        chk("rst_denied", accessDenied, 0);
        chk("rst_locked", locked, 0);
        chk("rst_guser", grantedUser, 0);
        chk("rst_count", digitCount, 0);

        // User 0 = 16'h1234, first digit is the low nibble: enter 4,3,2,1.
        g0 = grantCyc; d0 = denyCyc;
        enter4(2'd0, 4'd4, 4'd3, 4'd2, 4'd1);
        cycles(1);
        chk("u0_lat1", accessGranted, 0);
        cycles(1);
        chk("u0_lat2", accessGranted, 1);
        chk("u0_guser", grantedUser, 0);
        cycles(10);
        chk("u0_grant_len", grantCyc - g0, 8);
        chk("u0_no_deny", denyCyc - d0, 0);
        chk("u0_cnt_clr", digitCount, 0);

        // User 1 = 16'h9090 (0,9,0,9): 5,5,4,5 is wrong.
        g0 = grantCyc; d0 = denyCyc;
        enter4(2'd1, 4'd5, 4'd5, 4'd4, 4'd5);
        cycles(1);
        chk("u1_lat1", accessDenied, 0);
        cycles(1);
        chk("u1_lat2", accessDenied, 1);
        cycles(10);
        chk("u1_deny_len", denyCyc - d0, 8);
        chk("u1_no_grant", grantCyc - g0, 0);

        // Timeout mid-entry.
        g0 = grantCyc; d0 = denyCyc;
        press(2'd2, 4'd9); press(2'd2, 4'd0);
        chk("to_cnt2", digitCount, 2);
        cycles(40);
        chk("to_cnt0", digitCount, 0);
        chk("to_no_pulse", (grantCyc - g0) + (denyCyc - d0), 0);

        // Held button yields a single press.
        @(negedge clk);
        userId = 2'd0; userInp = 4'd1; userBtn = 1'b1;
        repeat (20) @(negedge clk);
        chk("hold_cnt", digitCount, 1);
        userBtn = 1'b0;
        cycles(40);
        chk("hold_abort", digitCount, 0);

        // Reset after three correct digits.
        press(2'd0, 4'd4); press(2'd0, 4'd3); press(2'd0, 4'd2);
        chk("rr_pre", digitCount, 3);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rr_async", digitCount, 0);
        @(negedge clk);
        reset = 1'b1;
        g0 = grantCyc; d0 = denyCyc;
        cycles(12);
        chk("rr_no_pulse", (grantCyc - g0) + (denyCyc - d0), 0);
        chk("rr_outs", {accessGranted, accessDenied, locked, grantedUser, digitCount}, 0);
        press(2'd0, 4'd4);
        chk("rr_one", digitCount, 1);
        cycles(40);

        // User 3 = 16'h0000: three wrong entries, then the correct one.
        d0 = denyCyc; l0 = lockCyc;
        for (int i = 0; i < 3; i++) begin
            enter4(2'd3, 4'd1, 4'd1, 4'd1, 4'd1);
            cycles(12);
        end
        press(2'd3, 4'd0);
        chk("lk_ignore", digitCount, LK ? 0 : 1);
        chk("lk_active", locked, LK);
        cycles(40);
        chk("lk_len", lockCyc - l0, LK ? 16 : 0);
        chk("lk_deny_len", denyCyc - d0, LK ? 40 : 24);
        chk("lk_off", locked, 0);
        chk("lk_cnt", digitCount, 0);

        g0 = grantCyc;
        enter4(2'd3, 4'd0, 4'd0, 4'd0, 4'd0);
        cycles(2);
        chk("u3_granted", accessGranted, 1);
        chk("u3_guser", grantedUser, 3);
        cycles(10);
        chk("u3_grant_len", grantCyc - g0, 8);
        chk("never_both", bothCyc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
